// File: rtl/nexys_starship_monster_bank.sv
// nexys_starship_monster_bank
// Multi-lane monster controller: each lane waits SPAWN_DELAY ticks while
// empty, spawns on a random request (lowest lane first, capped at MAX_ACTIVE
// live monsters), then runs an expiry timer. A shielded expiry is a kill; an
// unshielded expiry ends the game and reports the lane. The slow game time
// base arrives as the single-cycle timer_tick enable.
module nexys_starship_monster_bank #(
  parameter int NUM_LANES   = 4,
  parameter int TW          = 8,
  parameter int TIMEOUT     = 15,
  parameter int WARN_TICKS  = 10,
  parameter int SPAWN_DELAY = 1,
  parameter int MAX_ACTIVE  = 2,
  parameter int KW          = 8,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 timer_tick,
  input  logic                 play_flag,
  input  logic                 gameover_ctrl,
  input  logic [NUM_LANES-1:0] shield,
  input  logic [NUM_LANES-1:0] random,
  output logic [NUM_LANES-1:0] monster,
  output logic [NUM_LANES-1:0] warn,
  output logic                 gameover,
  output logic [LW-1:0]        gameover_lane,
  output logic [KW-1:0]        kills,
  output logic                 q_Init,
  output logic                 q_Play,
  output logic                 q_Over
);

  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);
  localparam logic [TW-1:0] WARN_T    = TW'(WARN_TICKS);
  localparam logic [TW-1:0] SPAWN_T   = TW'(SPAWN_DELAY);
  localparam logic [3:0]    MAX_ACT_T = 4'(MAX_ACTIVE);
  localparam int            KSW       = KW + 4;
  localparam logic [KSW-1:0] KMAX     = {{4{1'b0}}, {KW{1'b1}}};

  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_PLAY = 3'b010,
    ST_OVER = 3'b100
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_LANES-1:0] r_monster;
  logic [NUM_LANES-1:0] r_warn;
  logic [TW-1:0]        r_timer [NUM_LANES];
  logic [TW-1:0]        r_delay [NUM_LANES];
  logic [KW-1:0]        r_kills;
  logic [LW-1:0]        r_golane;

  logic [NUM_LANES-1:0] w_expired;
  logic [NUM_LANES-1:0] w_kill;
  logic [NUM_LANES-1:0] w_loss;
  logic [NUM_LANES-1:0] w_armed;
  logic [NUM_LANES-1:0] w_cand;
  logic [NUM_LANES-1:0] w_spawn;
  logic [NUM_LANES-1:0] w_monster_nxt;
  logic [NUM_LANES-1:0] w_warn_nxt;
  logic [TW-1:0]        w_timer_nxt [NUM_LANES];
  logic [TW-1:0]        w_delay_nxt [NUM_LANES];
  logic [LW-1:0]        w_loss_lane;
  logic [KW-1:0]        w_kills_nxt;
  logic                 w_cap_ok;
  logic                 w_run;
  logic                 w_go_over;
  logic                 w_clear;

  // Saturating +1 for the per-lane timer and delay counters.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Number of set bits in a lane vector (NUM_LANES <= 8 fits in 4 bits).
  function automatic logic [3:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // Kill counter add that sticks at all-ones.
  function automatic logic [KW-1:0] sat_add_kills(input logic [KW-1:0] a,
                                                  input logic [3:0]    n);
    logic [KSW-1:0] s;
    s = KSW'(a) + KSW'(n);
    return (s > KMAX) ? {KW{1'b1}} : s[KW-1:0];
  endfunction

  // Per-lane expiry, arming, spawn arbitration and next-value computation.
  always_comb begin
    w_expired     = '0;
    w_kill        = '0;
    w_loss        = '0;
    w_armed       = '0;
    w_cand        = '0;
    w_spawn       = '0;
    w_loss_lane   = '0;
    w_cap_ok      = 1'b0;
    w_monster_nxt = r_monster;
    w_warn_nxt    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_timer_nxt[i] = r_timer[i];
      w_delay_nxt[i] = r_delay[i];
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      w_expired[i] = r_monster[i] && (r_timer[i] >= TIMEOUT_T);
      w_armed[i]   = !r_monster[i] && (r_delay[i] >= SPAWN_T);
    end
    w_kill   = w_expired & shield;
    w_loss   = w_expired & ~shield;
    w_cand   = w_armed & random & ~r_monster;
    // Cap uses the occupancy before any kill lands this cycle.
    w_cap_ok = popcount(r_monster) < MAX_ACT_T;

    // Scan downwards so the lowest index is the one left standing.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_loss[i]) w_loss_lane = LW'(i);
      if (w_cand[i] && w_cap_ok) begin
        w_spawn    = '0;
        w_spawn[i] = 1'b1;
      end
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_kill[i]) begin
        w_monster_nxt[i] = 1'b0;
        w_timer_nxt[i]   = '0;
        w_delay_nxt[i]   = '0;
      end else if (w_spawn[i]) begin
        w_monster_nxt[i] = 1'b1;
        w_timer_nxt[i]   = '0;
        w_delay_nxt[i]   = '0;
      end else if (r_monster[i]) begin
        if (timer_tick) w_timer_nxt[i] = sat_inc(r_timer[i]);
      end else begin
        if (timer_tick) w_delay_nxt[i] = sat_inc(r_delay[i]);
      end
      w_warn_nxt[i] = w_monster_nxt[i] && (w_timer_nxt[i] >= WARN_T);
    end

    w_kills_nxt = sat_add_kills(r_kills, popcount(w_kill));
  end

  // Game-level next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (play_flag) w_state_nxt = ST_PLAY;
      ST_PLAY: if (gameover_ctrl || (|w_loss)) w_state_nxt = ST_OVER;
      ST_OVER: if (!play_flag && !gameover_ctrl) w_state_nxt = ST_INIT;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Lanes advance only on a PLAY cycle that stays in PLAY; the cycle that
  // ends the game freezes everything as it was.
  assign w_run     = (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY);
  assign w_go_over = (r_state == ST_PLAY) && (w_state_nxt == ST_OVER);
  assign w_clear   = (r_state == ST_INIT) || (w_state_nxt == ST_INIT);

  // Game state register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Lane state, warn, kill counter and gameover lane registers.
  always_ff @(posedge Clk) begin
    if (Reset || w_clear) begin
      r_monster <= '0;
      r_warn    <= '0;
      r_kills   <= '0;
      r_golane  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_timer[i] <= '0;
        r_delay[i] <= '0;
      end
    end else if (w_run) begin
      r_monster <= w_monster_nxt;
      r_warn    <= w_warn_nxt;
      r_kills   <= w_kills_nxt;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_timer[i] <= w_timer_nxt[i];
        r_delay[i] <= w_delay_nxt[i];
      end
    end else if (w_go_over) begin
      r_warn   <= '0;
      r_golane <= gameover_ctrl ? '0 : w_loss_lane;
    end else begin
      r_warn <= '0;
    end
  end

  assign monster       = r_monster;
  assign warn          = r_warn;
  assign kills         = r_kills;
  assign gameover_lane = r_golane;
  assign gameover      = (r_state == ST_OVER);
  assign q_Init        = (r_state == ST_INIT);
  assign q_Play        = (r_state == ST_PLAY);
  assign q_Over        = (r_state == ST_OVER);

endmodule

// File: tb/tb_nexys_starship_monster_bank.sv
// Scoreboard bench for nexys_starship_monster_bank: a stimulus process drives
// directed scenarios and a randomized phase, advances a behavioural game model
// and queues the expected outputs; a monitor compares them after every edge.
module tb_nexys_starship_monster_bank;

  localparam int NL   = 4;
  localparam int TW   = 8;
  localparam int TO   = 15;
  localparam int WT   = 10;
  localparam int SD   = 1;
  localparam int MA   = 2;
  localparam int KW   = 4;
  localparam int LW   = 2;
  localparam int KMAX = (1 << KW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          timer_tick;
  logic          play_flag;
  logic          gameover_ctrl;
  logic [NL-1:0] shield;
  logic [NL-1:0] random;
  logic [NL-1:0] monster;
  logic [NL-1:0] warn;
  logic          gameover;
  logic [LW-1:0] gameover_lane;
  logic [KW-1:0] kills;
  logic          q_Init, q_Play, q_Over;

  always #5 Clk = ~Clk;

  nexys_starship_monster_bank #(
    .NUM_LANES(NL), .TW(TW), .TIMEOUT(TO), .WARN_TICKS(WT),
    .SPAWN_DELAY(SD), .MAX_ACTIVE(MA), .KW(KW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .timer_tick(timer_tick), .play_flag(play_flag),
    .gameover_ctrl(gameover_ctrl), .shield(shield), .random(random),
    .monster(monster), .warn(warn), .gameover(gameover),
    .gameover_lane(gameover_lane), .kills(kills),
    .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over)
  );

  typedef struct packed {
    logic [NL-1:0] mon;
    logic [NL-1:0] wrn;
    logic          go;
    logic [LW-1:0] lane;
    logic [KW-1:0] kl;
    logic          qi;
    logic          qp;
    logic          qo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // Behavioural game model: 0 = INIT, 1 = PLAY, 2 = OVER.
  int m_state;
  int m_mon[NL];
  int m_tmr[NL];
  int m_dly[NL];
  int m_kills;
  int m_lane;

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) begin
      m_mon[i] = 0; m_tmr[i] = 0; m_dly[i] = 0;
    end
    m_kills = 0;
    m_lane  = 0;
  endfunction

  function automatic void model_step(input logic rst, tk, pf, goc,
                                     input logic [NL-1:0] sh, rn);
    int loss, active, winner, nk;
    if (rst) begin
      model_clear();
      m_state = 0;
      return;
    end
    if (m_state == 0) begin
      model_clear();
      if (pf) m_state = 1;
    end else if (m_state == 2) begin
      if (!pf && !goc) begin
        model_clear();
        m_state = 0;
      end
    end else begin
      loss = -1;
      for (int i = 0; i < NL; i++)
        if (loss < 0 && m_mon[i] == 1 && m_tmr[i] >= TO && !sh[i]) loss = i;
      if (goc || loss >= 0) begin
        m_state = 2;
        m_lane  = goc ? 0 : loss;
        return;
      end
      active = 0;
      for (int i = 0; i < NL; i++) active += m_mon[i];
      winner = -1;
      if (active < MA)
        for (int i = 0; i < NL; i++)
          if (winner < 0 && m_mon[i] == 0 && m_dly[i] >= SD && rn[i]) winner = i;
      nk = 0;
      for (int i = 0; i < NL; i++) begin
        if (m_mon[i] == 1) begin
          if (m_tmr[i] >= TO) begin
            m_mon[i] = 0; m_tmr[i] = 0; m_dly[i] = 0; nk++;
          end else if (tk) begin
            m_tmr[i] = (m_tmr[i] < TMAX) ? m_tmr[i] + 1 : TMAX;
          end
        end else if (i == winner) begin
          m_mon[i] = 1; m_tmr[i] = 0; m_dly[i] = 0;
        end else if (tk) begin
          m_dly[i] = (m_dly[i] < TMAX) ? m_dly[i] + 1 : TMAX;
        end
      end
      m_kills = (m_kills + nk > KMAX) ? KMAX : m_kills + nk;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < NL; i++) begin
      e.mon[i] = (m_mon[i] == 1);
      e.wrn[i] = (m_state == 1) && (m_mon[i] == 1) && (m_tmr[i] >= WT);
    end
    e.go   = (m_state == 2);
    e.lane = LW'(m_lane);
    e.kl   = KW'(m_kills);
    e.qi   = (m_state == 0);
    e.qp   = (m_state == 1);
    e.qo   = (m_state == 2);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic rst, tk, pf, goc, input logic [NL-1:0] sh, rn);
    @(negedge Clk);
    Reset         = rst;
    timer_tick    = tk;
    play_flag     = pf;
    gameover_ctrl = goc;
    shield        = sh;
    random        = rn;
    model_step(rst, tk, pf, goc, sh, rn);
    sb_q.push_back(model_out());
    cyc++;
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("monster",       32'(monster),       32'(e.mon));
        check("warn",          32'(warn),          32'(e.wrn));
        check("gameover",      32'(gameover),      32'(e.go));
        check("gameover_lane", 32'(gameover_lane), 32'(e.lane));
        check("kills",         32'(kills),         32'(e.kl));
        check("q_Init",        32'(q_Init),        32'(e.qi));
        check("q_Play",        32'(q_Play),        32'(e.qp));
        check("q_Over",        32'(q_Over),        32'(e.qo));
      end
    end
  end

  initial begin
    logic          tk, rst, pf, goc;
    logic [NL-1:0] sh, rn;
    Reset = 1'b1; timer_tick = 1'b0; play_flag = 1'b0; gameover_ctrl = 1'b0;
    shield = '0; random = '0;
    model_clear();
    m_state = 0;

    // Reset, then a single lane spawning, warning and being killed by shield.
    repeat (3) drive(1, 0, 0, 0, '0, '0);
    for (int k = 0; k < 200; k++) drive(0, (cyc % 4) == 0, 1, 0, 4'b0001, 4'b0001);

    // All lanes requesting: cap of two live monsters, shields everywhere.
    for (int k = 0; k < 120; k++) drive(0, (cyc % 4) == 0, 1, 0, 4'b1111, 4'b1111);

    // Lanes 1 and 3 expire together unshielded: lowest lane reported.
    repeat (2) drive(1, 0, 0, 0, '0, '0);
    for (int k = 0; k < 400 && m_state != 2; k++)
      drive(0, (cyc % 4) == 0, 1, 0, 4'b0000, 4'b1010);
    if (m_state != 2) begin
      n_checks++; n_errors++;
      $display("FAIL dual_expiry_timeout cyc=%0d got=no_over exp=over", cyc);
    end else begin
      @(posedge Clk); #1;
      check("dual_q_Over", 32'(q_Over), 32'd1);
      check("dual_lane",   32'(gameover_lane), 32'd1);
      check("dual_monster", 32'(monster), 32'b1010);
    end
    for (int k = 0; k < 6; k++) drive(0, (cyc % 4) == 0, 1, 0, 4'b0000, 4'b1111);
    repeat (3) drive(0, 0, 0, 0, '0, '0);

    // Forced gameover in PLAY, then return to INIT.
    for (int k = 0; k < 40; k++) drive(0, (cyc % 4) == 0, 1, 0, 4'b1111, 4'b1111);
    drive(0, 0, 1, 1, 4'b1111, 4'b1111);
    @(posedge Clk); #1;
    check("ctrl_q_Over", 32'(q_Over), 32'd1);
    check("ctrl_lane",   32'(gameover_lane), 32'd0);
    repeat (3) drive(0, 1, 1, 0, 4'b1111, 4'b1111);
    drive(0, 0, 0, 0, '0, '0);
    @(posedge Clk); #1;
    check("ctrl_q_Init", 32'(q_Init), 32'd1);
    check("ctrl_kills",  32'(kills), 32'd0);

    // Reset in the middle of a game with two live monsters.
    for (int k = 0; k < 30; k++) drive(0, (cyc % 4) == 0, 1, 0, 4'b0000, 4'b1111);
    @(posedge Clk); #1;
    check("pre_rst_monster", 32'(monster), 32'b0011);
    drive(1, 1, 1, 0, 4'b0000, 4'b1111);
    @(posedge Clk); #1;
    check("rst_monster", 32'(monster), 32'd0);
    check("rst_warn",    32'(warn), 32'd0);
    check("rst_kills",   32'(kills), 32'd0);
    check("rst_q_Init",  32'(q_Init), 32'd1);

    // Fast ticks with permanent shields: counters saturate.
    drive(0, 0, 0, 0, '0, '0);
    for (int k = 0; k < 320; k++) drive(0, 1, 1, 0, 4'b1111, 4'b0011);
    for (int k = 0; k < 200; k++) drive(0, 1, 1, 0, 4'b1111, 4'b1111);
    @(posedge Clk); #1;
    check("kills_saturated", 32'(kills), 32'(KMAX));

    // Randomized play.
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      pf  = ($urandom_range(0, 19) != 0);
      goc = ($urandom_range(0, 299) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NL; i++) sh[i] = ($urandom_range(0, 7) != 0);
      rn  = NL'($urandom);
      drive(rst, tk, pf, goc, sh, rn);
    end

    repeat (3) @(posedge Clk);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
